// File: rtl/ram_stream_reader.sv
// Burst reader: streams len words from a RAM read port starting at base_addr.
// First word RL+2 cycles after start, then 1 word/cycle; m_ready low stalls reads via FIFO credit.

module ram_stream_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    output logic          rd_vld,
    output logic [W-1:0]  rd_dat,
    input  logic          rd_rdy,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign push   = wr_vld && (cnt != CW'(DEPTH));
    assign pop    = rd_rdy && (cnt != '0);
    assign rd_vld = (cnt != '0);
    assign rd_dat = mem[rd_ptr];
    assign count  = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end
endmodule

module ram_stream_reader #(
    parameter int  RAM_WIDTH    = 18,
    parameter int  RAM_DEPTH    = 1024,
    parameter int  READ_LATENCY = 2,
    parameter int  FIFO_DEPTH   = 4,
    localparam int ADDR_W       = $clog2(RAM_DEPTH)
) (
    input  logic                 clka,
    input  logic                 rsta,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      len,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic                 ram_en,
    output logic                 ram_regce,
    input  logic [RAM_WIDTH-1:0] ram_dout,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last
);
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                   state;
    state_t                   state_d;
    logic [ADDR_W:0]          len_q;
    logic [ADDR_W:0]          issued;
    logic [ADDR_W-1:0]        addr_ptr;
    logic [READ_LATENCY-1:0]  vld_pipe;
    logic [READ_LATENCY-1:0]  last_pipe;
    logic                     issue_d;
    logic                     done_d;
    logic                     pop;
    logic                     last_hs;
    logic [CW-1:0]            fifo_count;
    logic [CW-1:0]            inflight;
    logic [CW-1:0]            occ;
    logic [RAM_WIDTH:0]       head;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(RAM_DEPTH - 1)) ? '0 : a + ADDR_W'(1);
    endfunction

    // Credit: reads on the port or in the RAM pipe are already owed a FIFO slot.
    always_comb begin
        inflight = CW'(ram_en);
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CW'(vld_pipe[i]);
        end
    end

    assign occ       = fifo_count + inflight;
    assign pop       = m_valid && m_ready;
    assign last_hs   = pop && m_last;
    assign ram_regce = (READ_LATENCY == 2) ? vld_pipe[0] : 1'b0;

    always_comb begin
        state_d = state;
        issue_d = 1'b0;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        issue_d = 1'b1;
                        state_d = READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if ((issued < len_q) && (occ < CW'(FIFO_DEPTH) + CW'(pop))) begin
                    issue_d = 1'b1;
                end
                if (ram_en && (issued == len_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_en    <= 1'b0;
            ram_addr  <= '0;
            addr_ptr  <= '0;
            len_q     <= '0;
            issued    <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            state        <= state_d;
            busy         <= (state_d != IDLE);
            done         <= done_d;
            ram_en       <= issue_d;
            vld_pipe[0]  <= ram_en;
            last_pipe[0] <= ram_en && (issued == len_q);
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
            if (issue_d) begin
                if (state == IDLE) begin
                    ram_addr <= base_addr;
                    addr_ptr <= wrap_inc(base_addr);
                    len_q    <= len;
                    issued   <= {{ADDR_W{1'b0}}, 1'b1};
                end else begin
                    ram_addr <= addr_ptr;
                    addr_ptr <= wrap_inc(addr_ptr);
                    issued   <= issued + 1'b1;
                end
            end
        end
    end

    ram_stream_fifo #(
        .W     (RAM_WIDTH + 1),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk    (clka),
        .rst    (rsta),
        .wr_vld (vld_pipe[READ_LATENCY-1]),
        .wr_dat ({last_pipe[READ_LATENCY-1], ram_dout}),
        .rd_vld (m_valid),
        .rd_dat (head),
        .rd_rdy (m_ready),
        .count  (fifo_count)
    );

    assign m_data = head[RAM_WIDTH-1:0];
    assign m_last = m_valid && head[RAM_WIDTH];
endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: READ_LATENCY=2 and =1 instances side by side on shared stimulus.
module tb_ram_stream_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] len = '0;
    logic        m_ready = 1'b1;

    wire  [1:0]  busy_w, done_w, en_w, regce_w, vld_w, last_w;
    wire  [9:0]  addr_w [2];
    wire  [17:0] data_w [2];
    logic [17:0] dout2, lat2, dout1;
    logic [17:0] mem [1024];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int start_cyc = 0;

    int en_n [2], hs_n [2], regce_n [2], done_n [2], done_cyc [2];
    int last_n [2], last_idx [2], last_cyc [2], first_vld [2];
    int stall_bad [2], max_occ [2];
    int data_a [2][64];
    int addr_a [2][64];
    logic        pv [2];
    logic [17:0] pd [2];
    logic        pr;

    typedef struct {
        int base;
        int len;
        int mode;
        int exp_first;
        int exp_last;
        int exp_en;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial for (int i = 0; i < 1024; i++) mem[i] = 18'(i);

    always @(posedge clk) begin
        if (en_w[0])    lat2  <= mem[addr_w[0]];
        if (regce_w[0]) dout2 <= lat2;
        if (en_w[1])    dout1 <= mem[addr_w[1]];
    end

    ram_stream_reader #(.RAM_WIDTH(18), .RAM_DEPTH(1024), .READ_LATENCY(2), .FIFO_DEPTH(4)) u_rl2 (
        .clka(clk), .rsta(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy_w[0]), .done(done_w[0]), .ram_addr(addr_w[0]), .ram_en(en_w[0]),
        .ram_regce(regce_w[0]), .ram_dout(dout2), .m_data(data_w[0]), .m_valid(vld_w[0]),
        .m_ready(m_ready), .m_last(last_w[0])
    );

    ram_stream_reader #(.RAM_WIDTH(18), .RAM_DEPTH(1024), .READ_LATENCY(1), .FIFO_DEPTH(4)) u_rl1 (
        .clka(clk), .rsta(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy_w[1]), .done(done_w[1]), .ram_addr(addr_w[1]), .ram_en(en_w[1]),
        .ram_regce(regce_w[1]), .ram_dout(dout1), .m_data(data_w[1]), .m_valid(vld_w[1]),
        .m_ready(m_ready), .m_last(last_w[1])
    );

    // Observe both instances mid-cycle; occupancy = reads issued minus words consumed.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                en_n[i] = 0; hs_n[i] = 0; regce_n[i] = 0; done_n[i] = 0; done_cyc[i] = -1;
                last_n[i] = 0; last_idx[i] = -1; last_cyc[i] = -1; first_vld[i] = -1;
                stall_bad[i] = 0; max_occ[i] = 0; pv[i] = 1'b0; pd[i] = '0;
            end else begin
                if (en_w[i]) begin
                    if (en_n[i] < 64) addr_a[i][en_n[i]] = int'(addr_w[i]);
                    en_n[i]++;
                end
                if (en_n[i] - hs_n[i] > max_occ[i]) max_occ[i] = en_n[i] - hs_n[i];
                if (regce_w[i]) regce_n[i]++;
                if (vld_w[i] && first_vld[i] < 0) first_vld[i] = cyc;
                if (pv[i] && !pr && (!vld_w[i] || data_w[i] != pd[i])) stall_bad[i]++;
                if (vld_w[i] && m_ready) begin
                    if (hs_n[i] < 64) data_a[i][hs_n[i]] = int'(data_w[i]);
                    if (last_w[i]) begin
                        last_n[i]++;
                        last_idx[i] = hs_n[i];
                        last_cyc[i] = cyc;
                    end
                    hs_n[i]++;
                end
                if (done_w[i]) begin
                    done_n[i]++;
                    done_cyc[i] = cyc;
                end
                pv[i] = vld_w[i];
                pd[i] = data_w[i];
            end
        end
        pr = m_ready;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic logic rdy_at(input int k);
        logic [31:0] pat;
        pat = 32'hB53C9AE1;
        if (k >= 6 && k < 16) return 1'b0;
        return pat[k[4:0]];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic launch(input int b, input int l);
        start = 1'b1;
        base_addr = 10'(b);
        len = 11'(l);
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int mode);
        int k;
        k = 0;
        while (done_n[0] == 0 && k < 300) begin
            m_ready = (mode != 0) ? rdy_at(k) : 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        if (done_n[0] == 0) check("done_timeout", 0, 1);
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input int i);
        check("rst_ctrl", int'({busy_w[i], done_w[i], en_w[i], regce_w[i], vld_w[i], last_w[i]}), 0);
        check("rst_addr", int'(addr_w[i]), 0);
    endtask

    initial begin
        vecs[0] = '{base: 5,    len: 4,  mode: 0, exp_first: 5,    exp_last: 8,    exp_en: 4};
        vecs[1] = '{base: 1022, len: 4,  mode: 0, exp_first: 1022, exp_last: 1,    exp_en: 4};
        vecs[2] = '{base: 0,    len: 1,  mode: 0, exp_first: 0,    exp_last: 0,    exp_en: 1};
        vecs[3] = '{base: 100,  len: 16, mode: 1, exp_first: 100,  exp_last: 115,  exp_en: 16};
        vecs[4] = '{base: 1023, len: 2,  mode: 0, exp_first: 1023, exp_last: 0,    exp_en: 2};

        do_reset();
        check_idle_outputs(0);
        check_idle_outputs(1);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            launch(vecs[v].base, vecs[v].len);
            wait_done(vecs[v].mode);
            for (int i = 0; i < 2; i++) begin
                check("words", hs_n[i], vecs[v].len);
                check("ram_en_pulses", en_n[i], vecs[v].exp_en);
                check("first_data", data_a[i][0], vecs[v].exp_first);
                check("last_data", data_a[i][vecs[v].len-1], vecs[v].exp_last);
                for (int j = 0; j < vecs[v].len; j++) begin
                    check("data_seq", data_a[i][j], (vecs[v].base + j) % 1024);
                    check("addr_seq", addr_a[i][j], (vecs[v].base + j) % 1024);
                end
                check("last_count", last_n[i], 1);
                check("last_index", last_idx[i], vecs[v].len - 1);
                check("done_count", done_n[i], 1);
                check("done_after_last", done_cyc[i] - last_cyc[i], 1);
                check("stall_stable", stall_bad[i], 0);
                check("occ_bound", int'(max_occ[i] <= 4), 1);
                check("first_latency", first_vld[i] - start_cyc, (i == 0) ? 4 : 3);
                check("regce_pulses", regce_n[i], (i == 0) ? vecs[v].len : 0);
                if (vecs[v].mode == 0) check("throughput", last_cyc[i] - first_vld[i], vecs[v].len - 1);
            end
        end

        // len=0: immediate done, no RAM traffic, no stream output.
        do_reset();
        launch(7, 0);
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("len0_done", done_n[i], 1);
            check("len0_done_cycle", done_cyc[i] - start_cyc, 1);
            check("len0_ram_en", en_n[i], 0);
            check("len0_valid", first_vld[i], -1);
        end

        // A second start while busy must be ignored.
        do_reset();
        launch(5, 4);
        start = 1'b1; base_addr = 10'd200; len = 11'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(0);
        check("busy_start_words", hs_n[0], 4);
        check("busy_start_first", data_a[0][0], 5);
        check("busy_start_last", data_a[0][3], 8);
        check("busy_start_done", done_n[0], 1);

        // Reset after the third word, then restart in the first cycle after reset drops.
        do_reset();
        launch(0, 8);
        begin
            int k;
            k = 0;
            while (hs_n[0] < 3 && k < 100) begin
                @(posedge clk);
                #1;
                k++;
            end
            if (hs_n[0] < 3) check("rst_wait_timeout", hs_n[0], 3);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle_outputs(0);
        check_idle_outputs(1);
        launch(0, 2);
        wait_done(0);
        for (int i = 0; i < 2; i++) begin
            check("post_rst_words", hs_n[i], 2);
            check("post_rst_d0", data_a[i][0], 0);
            check("post_rst_d1", data_a[i][1], 1);
            check("post_rst_done", done_n[i], 1);
            check("post_rst_last", last_idx[i], 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
